// File: rtl/screen_pkg.sv
// Shared screen encoding and default button geometry for the screen controller.
package screen_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        SCR_START = 4'b0001,
        SCR_GAME  = 4'b0010,
        SCR_PAUSE = 4'b0100,
        SCR_END   = 4'b1000
    } screen_t;

    localparam int DEF_BTN_X  = 352;
    localparam int DEF_BTN_W  = 96;
    localparam int DEF_BTN_H  = 32;
    localparam int DEF_BTN0_Y = 200;
    localparam int DEF_BTN1_Y = 300;

endpackage

// File: rtl/mouse_click_edge.sv
// Registered rising-edge detector for one mouse button; one-cycle click per press.
module mouse_click_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic click_o
);

    logic btn_q;

    // History resets high so a button held through reset release is not a click.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign click_o = btn_i & ~btn_q;

endmodule

// File: rtl/screen_ctrl_fsm.sv
// START/GAME/PAUSE/END screen sequencer with button hit test and game timer.
// Optional post-transition click lockout: define SCREEN_CTRL_LOCKOUT_EN.
module screen_ctrl_fsm
    import screen_pkg::*;
#(
    parameter int XW          = 12,
    parameter int YW          = 12,
    parameter int BTN_X       = DEF_BTN_X,
    parameter int BTN_W       = DEF_BTN_W,
    parameter int BTN_H       = DEF_BTN_H,
    parameter int BTN0_Y      = DEF_BTN0_Y,
    parameter int BTN1_Y      = DEF_BTN1_Y,
    parameter int CLK_HZ      = 65_000_000,
    parameter int GAME_SEC    = 60,
    parameter int SEC_W       = 8,
    parameter int LOCKOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mouse_left,
    input  logic               mouse_right,
    input  logic [XW-1:0]      xpos,
    input  logic [YW-1:0]      ypos,
    input  logic               game_over,
    output logic [STATE_W-1:0] state_bin,
    output logic               state_chg,
    output logic [SEC_W-1:0]   sec_cnt
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    // Bounds carry one extra bit so BTN_X+BTN_W cannot wrap.
    localparam logic [XW:0] X_LO  = (XW+1)'(BTN_X);
    localparam logic [XW:0] X_HI  = (XW+1)'(BTN_X + BTN_W);
    localparam logic [YW:0] Y0_LO = (YW+1)'(BTN0_Y);
    localparam logic [YW:0] Y0_HI = (YW+1)'(BTN0_Y + BTN_H);
    localparam logic [YW:0] Y1_LO = (YW+1)'(BTN1_Y);
    localparam logic [YW:0] Y1_HI = (YW+1)'(BTN1_Y + BTN_H);

    screen_t          state_q, state_d;
    logic             chg_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SEC_W-1:0] sec_q, sec_d;

    logic lclick_raw, rclick_raw;
    logic lclick, rclick;
    logic click_en;
    logic hit0, hit1, in_x;
    logic expire;
    logic [XW:0] x_ext;
    logic [YW:0] y_ext;

    mouse_click_edge u_left_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (mouse_left),
        .click_o (lclick_raw)
    );

    mouse_click_edge u_right_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (mouse_right),
        .click_o (rclick_raw)
    );

    assign x_ext = {1'b0, xpos};
    assign y_ext = {1'b0, ypos};
    assign in_x  = (x_ext >= X_LO) && (x_ext <= X_HI);
    assign hit0  = in_x && (y_ext >= Y0_LO) && (y_ext <= Y0_HI);
    assign hit1  = in_x && (y_ext >= Y1_LO) && (y_ext <= Y1_HI);

`ifdef SCREEN_CTRL_LOCKOUT_EN
    localparam int LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    logic [LW-1:0] lock_q, lock_d;

    always_comb begin
        lock_d = lock_q;
        if (state_d != state_q) begin
            lock_d = LW'(LOCKOUT_CYC - 1);
        end else if (lock_q != '0) begin
            lock_d = lock_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign click_en = (lock_q == '0);
`else
    // Lockout length has no effect without the lockout counter.
    logic [31:0] unused_lockout_cyc;
    assign unused_lockout_cyc = LOCKOUT_CYC;
    assign click_en = 1'b1;
`endif

    assign lclick = lclick_raw & click_en;
    assign rclick = rclick_raw & click_en;
    assign expire = (GAME_SEC != 0) && (sec_q == SEC_W'(GAME_SEC)) && (presc_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCR_START: begin
                if (lclick && (hit0 || hit1)) state_d = SCR_GAME;
            end
            SCR_GAME: begin
                if (game_over)   state_d = SCR_END;
                else if (expire) state_d = SCR_END;
                else if (rclick) state_d = SCR_PAUSE;
            end
            SCR_PAUSE: begin
                if (rclick)              state_d = SCR_GAME;
                else if (lclick && hit0) state_d = SCR_START;
            end
            SCR_END: begin
                if (lclick && hit0)      state_d = SCR_START;
                else if (lclick && hit1) state_d = SCR_GAME;
            end
            default: state_d = SCR_START;
        endcase
    end

    // Timer runs only in GAME; a fresh game or return to START clears it.
    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (state_q == SCR_GAME) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (sec_q != '1) sec_d = sec_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if ((state_d == SCR_GAME) && ((state_q == SCR_START) || (state_q == SCR_END))) begin
            presc_d = '0;
            sec_d   = '0;
        end
        if ((state_d == SCR_START) && (state_q != SCR_START)) begin
            presc_d = '0;
            sec_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCR_START;
            chg_q   <= 1'b0;
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            state_q <= state_d;
            chg_q   <= (state_d != state_q);
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

    assign state_bin = state_q;
    assign state_chg = chg_q;
    assign sec_cnt   = sec_q;

endmodule

// File: doc/screen_ctrl_fsm.md
Name: screen_ctrl_fsm

Overview:
- Parametrised top-level screen controller for the VGA mouse game.
- Sequences four screens: START, GAME, PAUSE, END.
- Inputs: registered mouse-click events hit-tested against two parametrised button rectangles, plus an external game_over flag and a built-in game timer.
- Drives the one-hot screen code consumed by the draw/mux stages, and exports elapsed game seconds to the HUD.

Parameters:
- XW, 12, xpos width in bits
- YW, 12, ypos width in bits
- BTN_X, 352, left edge of both buttons (px)
- BTN_W, 96, button width (px)
- BTN_H, 32, button height (px)
- BTN0_Y, 200, top edge of button 0 (px)
- BTN1_Y, 300, top edge of button 1 (px)
- CLK_HZ, 65_000_000, clk frequency; one second = CLK_HZ cycles
- GAME_SEC, 60, game time limit in seconds; 0 = no limit
- SEC_W, 8, width of sec_cnt
- LOCKOUT_CYC, 1024, click lockout length (cycles); used only with the optional feature

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst_n  in  1  asynchronous, active-low reset
- mouse_left  in  1  left button level, already synchronous to clk
- mouse_right  in  1  right button level, already synchronous to clk
- xpos  in  XW  cursor x
- ypos  in  YW  cursor y
- game_over  in  1  level; the game logic requests the END screen
- state_bin  out  4  one-hot screen: 0001 START, 0010 GAME, 0100 PAUSE, 1000 END
- state_chg  out  1  one-cycle pulse on the cycle after any state change
- sec_cnt  out  SEC_W  whole seconds elapsed in the current game

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = START, state_bin = 0001, state_chg = 0, sec_cnt = 0.
  - Prescaler and edge-detect history are cleared; history resets to 1, so a button held through reset release does not produce a click.
- state_bin is the state register itself (no one-cycle lag). A transition decided in cycle n is visible at state_bin in cycle n+1; state_chg = 1 in cycle n+1 only.
- Click detection:
  - lclick = mouse_left & ~mouse_left_q; rclick likewise for mouse_right.
  - Each is exactly one cycle per press; holding a button never repeats.
- Hit test (combinational, inclusive bounds):
  - hitK = (BTN_X <= xpos <= BTN_X+BTN_W) && (BTNK_Y <= ypos <= BTNK_Y+BTN_H).
  - Sums are computed at XW+1 / YW+1 bits so there is no wrap.
- Transitions (priority top-down within each state):
  - START: lclick & (hit0 | hit1) -> GAME. Otherwise stay.
  - GAME:
    - game_over -> END
    - else timer expiry -> END
    - else rclick -> PAUSE
    - else stay.
    - Left clicks are ignored in GAME.
  - PAUSE:
    - rclick -> GAME (resume; timer state preserved)
    - lclick & hit0 -> START (quit)
    - both in the same cycle: rclick wins.
    - game_over is ignored in PAUSE.
  - END:
    - lclick & hit0 -> START
    - lclick & hit1 -> GAME (restart)
    - buttons never overlap with the defaults; if they overlap, hit0 wins.
- Game timer:
  - The prescaler counts 0..CLK_HZ-1 only while in GAME. On wrap, sec_cnt increments, saturating at 2^SEC_W-1.
  - PAUSE freezes both prescaler and sec_cnt.
  - Expiry is when GAME_SEC != 0 and sec_cnt == GAME_SEC with the prescaler at 0, i.e. the cycle after the increment. The FSM then enters END.
  - Entering GAME from START or END clears the prescaler and sec_cnt. Entering GAME from PAUSE does not.
  - sec_cnt holds its value in END and is cleared on entering START.
- Hit test uses xpos/ypos sampled in the same cycle as the click edge.

Optional Feature:
- Macro: SCREEN_CTRL_LOCKOUT_EN.
- When defined:
  - A lockout counter loads LOCKOUT_CYC-1 on every state change.
  - lclick and rclick are masked while the counter is nonzero.
  - Purpose: a press arriving just after a screen switch cannot also hit a button at the same position on the new screen.
  - game_over and timer expiry are never masked.
- When undefined: no counter is instantiated, and clicks act on the cycle they occur.

Decomposition:
- Package screen_pkg holds:
  - the screen_t enum (logic [3:0], one-hot values as above);
  - default button geometry constants, which the parameters default to;
  - the STATE_W constant.
- Sub-module mouse_click_edge: per-button registered edge detector, asynchronous active-low reset, with the history flop resetting to 1. Instantiated twice (left, right).
- Hit test and FSM stay in screen_ctrl_fsm.

Test Plan:
- Release reset with mouse_left=1 held, cursor (400,210) -> no click generated; state_bin stays 0001. Release then press -> state_bin = 0010 one cycle after the edge, state_chg pulses once.
- START, left click at boundary points (352,200), (448,232), then (449,232) -> first two enter GAME; (449,232) is a miss and the state stays 0001.
- CLK_HZ=10, GAME_SEC=3, in GAME:
  - after 30 cycles, sec_cnt=3 and state_bin=1000 on the next cycle;
  - a right click at cycle 15 pauses with sec_cnt=1; resume -> expiry 30 GAME cycles total.
- GAME, game_over and rclick in the same cycle -> END (1000), not PAUSE.
- END:
  - click at (400,310) -> GAME with sec_cnt=0;
  - click at (400,210) -> START.
- SCREEN_CTRL_LOCKOUT_EN, LOCKOUT_CYC=8: click 3 cycles after entering GAME via START is ignored; click at cycle 9 is accepted. Assert rst_n low mid-GAME -> immediately 0001, sec_cnt=0.
